// File: rtl/msg_frame_gen.sv
// msg_frame_gen: length-prefixed message frame generator with an AXI-Stream style master port.
// Cycles round-robin through N_MSG stored messages, each prefixed with a 2-byte big-endian length.
// Optional build macro MSG_FRAME_SEQ_NUM_EN inserts an 8-bit sequence byte after the length header.
//
// state  | meaning
// IDLE   | waiting for enable_i
// GAP    | counting idle cycles before a frame
// SEND   | presenting beats of the current frame
// DONE   | FRAME_COUNT frames sent, held until reset
module msg_frame_gen #(
    parameter int unsigned BYTES       = 1,
    parameter int unsigned N_MSG       = 2,
    parameter int unsigned MAX_LEN     = 16,
    parameter logic [16*N_MSG-1:0]         MSG_LENS = {16'd11, 16'd5},
    parameter logic [8*MAX_LEN*N_MSG-1:0]  MESSAGES = {"HELLO WORLD", 40'h0, "ABCDE", 88'h0},
    parameter int unsigned GAP_CYCLES  = 10,
    parameter int unsigned FRAME_COUNT = 20
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               tready_i,
    output logic               tvalid_o,
    output logic [8*BYTES-1:0] tdata_o,
    output logic [BYTES-1:0]   tkeep_o,
    output logic               tlast_o,
    output logic               busy_o,
    output logic [15:0]        frames_sent_o,
    output logic               done_o
);

`ifdef MSG_FRAME_SEQ_NUM_EN
    localparam int unsigned HDR = 3;
`else
    localparam int unsigned HDR = 2;
`endif
    localparam int unsigned MW = (N_MSG > 1) ? $clog2(N_MSG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SEND, S_DONE} state_t;

    // Reject illegal configurations at elaboration time.
    if (BYTES != 1 && BYTES != 2 && BYTES != 4 && BYTES != 8) begin : g_bytes_chk
        $error("msg_frame_gen: BYTES must be 1, 2, 4 or 8");
    end
    for (genvar gi = 0; gi < N_MSG; gi++) begin : g_len_chk
        if (MSG_LENS[16*gi +: 16] == 16'd0 || 32'(MSG_LENS[16*gi +: 16]) > MAX_LEN) begin : g_bad
            $error("msg_frame_gen: MSG_LENS entry %0d out of range", gi);
        end
    end

    state_t          state_q, state_d;
    logic [31:0]     gap_cnt_q, gap_cnt_d;
    logic [15:0]     beat_q, beat_d;
    logic [MW-1:0]   msg_idx_q, msg_idx_d;
    logic [15:0]     frames_sent_q, frames_sent_d;

    logic [15:0]     cur_len;
    logic [15:0]     frame_size;
    logic [15:0]     frames_sent_inc;
    logic            last_beat;
    logic            hs;

    assign cur_len         = MSG_LENS[32'(msg_idx_q)*16 +: 16];
    assign frame_size      = cur_len + 16'(HDR);
    assign frames_sent_inc = frames_sent_q + 16'd1;
    assign last_beat       = ((32'(beat_q) + 32'd1) * BYTES) >= 32'(frame_size);
    assign hs              = tvalid_o && tready_i;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable_i) state_d = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
            S_GAP:  if (gap_cnt_q == GAP_CYCLES - 1) state_d = S_SEND;
            S_SEND: begin
                if (hs && last_beat) begin
                    if (FRAME_COUNT != 0 && frames_sent_inc == 16'(FRAME_COUNT)) state_d = S_DONE;
                    else if (enable_i) state_d = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
                    else               state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: gap counter, beat index, message index, frame count.
    always_comb begin
        gap_cnt_d     = gap_cnt_q;
        beat_d        = beat_q;
        msg_idx_d     = msg_idx_q;
        frames_sent_d = frames_sent_q;
        case (state_q)
            S_IDLE: gap_cnt_d = '0;
            S_GAP:  gap_cnt_d = gap_cnt_q + 32'd1;
            S_SEND: begin
                if (hs) begin
                    if (last_beat) begin
                        beat_d        = '0;
                        gap_cnt_d     = '0;
                        frames_sent_d = frames_sent_inc;
                        msg_idx_d     = (msg_idx_q == MW'(N_MSG - 1)) ? '0 : msg_idx_q + MW'(1);
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gap_cnt_q     <= '0;
            beat_q        <= '0;
            msg_idx_q     <= '0;
            frames_sent_q <= '0;
        end else begin
            gap_cnt_q     <= gap_cnt_d;
            beat_q        <= beat_d;
            msg_idx_q     <= msg_idx_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    // Outputs decoded from registered state; lane j carries frame byte beat*BYTES+j.
    always_comb begin
        int unsigned pos;
        int unsigned slot_top;
        pos      = 0;
        slot_top = 8 * MAX_LEN * (32'(msg_idx_q) + 1) - 1;
        tvalid_o = (state_q == S_SEND);
        tlast_o  = (state_q == S_SEND) && last_beat;
        busy_o   = (state_q == S_GAP) || (state_q == S_SEND);
        done_o   = (state_q == S_DONE);
        frames_sent_o = frames_sent_q;
        tdata_o  = '0;
        tkeep_o  = '0;
        if (state_q == S_SEND) begin
            for (int j = 0; j < BYTES; j++) begin
                pos = 32'(beat_q) * BYTES + j;
                if (pos < 32'(frame_size)) begin
                    tkeep_o[j] = 1'b1;
                    if (pos == 0)      tdata_o[8*j +: 8] = cur_len[15:8];
                    else if (pos == 1) tdata_o[8*j +: 8] = cur_len[7:0];
`ifdef MSG_FRAME_SEQ_NUM_EN
                    else if (pos == 2) tdata_o[8*j +: 8] = frames_sent_q[7:0];
`endif
                    else               tdata_o[8*j +: 8] = MESSAGES[slot_top - 8*(pos - HDR) -: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_frame_gen.sv
// Scoreboard bench for msg_frame_gen: a 1-byte instance (two messages) and a 4-byte instance.
module tb_msg_frame_gen;

    localparam int GAP = 10;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        enable1, tready1, tvalid1, tlast1, busy1, done1;
    logic [7:0]  tdata1;
    logic [0:0]  tkeep1;
    logic [15:0] fs1;
    logic        enable4, tready4, tvalid4, tlast4, busy4, done4;
    logic [31:0] tdata4;
    logic [3:0]  tkeep4;
    logic [15:0] fs4;

    msg_frame_gen #(
        .BYTES(1), .N_MSG(2), .MAX_LEN(16),
        .MSG_LENS({16'd5, 16'd11}),
        .MESSAGES({"ABCDE", 88'h0, "HELLO WORLD", 40'h0}),
        .GAP_CYCLES(GAP), .FRAME_COUNT(3)
    ) u1 (
        .clk_i(clk), .reset_i(reset), .enable_i(enable1), .tready_i(tready1),
        .tvalid_o(tvalid1), .tdata_o(tdata1), .tkeep_o(tkeep1), .tlast_o(tlast1),
        .busy_o(busy1), .frames_sent_o(fs1), .done_o(done1)
    );

    msg_frame_gen #(
        .BYTES(4), .N_MSG(2), .MAX_LEN(8),
        .MSG_LENS({16'd5, 16'd2}),
        .MESSAGES({"ABCDE", 24'h0, "HI", 48'h0}),
        .GAP_CYCLES(GAP), .FRAME_COUNT(2)
    ) u4 (
        .clk_i(clk), .reset_i(reset), .enable_i(enable4), .tready_i(tready4),
        .tvalid_o(tvalid4), .tdata_o(tdata4), .tkeep_o(tkeep4), .tlast_o(tlast4),
        .busy_o(busy4), .frames_sent_o(fs4), .done_o(done4)
    );

    int total = 0;
    int bad   = 0;
    beat_t q1[$];
    beat_t q4[$];
    logic [7:0] seq1 = 8'd0;
    bit   rand1 = 1'b0;
    bit   gap_chk1 = 1'b0;
    int   hs1 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h expected nothing", nm, act);
    endtask

    task automatic push_frame1(input int m);
        string s;
        logic [7:0] bytes[$];
        beat_t b;
        s = (m == 0) ? "HELLO WORLD" : "ABCDE";
        bytes.push_back(8'h00);
        bytes.push_back(8'(s.len()));
`ifdef MSG_FRAME_SEQ_NUM_EN
        bytes.push_back(seq1);
`endif
        for (int i = 0; i < s.len(); i++) bytes.push_back(s[i]);
        for (int i = 0; i < bytes.size(); i++) begin
            b.d = 32'(bytes[i]);
            b.k = 4'h1;
            b.l = (i == bytes.size() - 1);
            q1.push_back(b);
        end
        seq1 = seq1 + 8'd1;
    endtask

    task automatic push4(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        q4.push_back(b);
    endtask

    // Tready driver for the byte-wide instance.
    initial begin
        tready1 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready1 = rand1 ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard for the byte-wide instance.
    logic       stall1 = 1'b0;
    logic [7:0] sd1;
    logic       sl1;
    bit         gap_arm1 = 1'b0;
    int         gap_cnt1 = 0;
    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            stall1   = 1'b0;
            gap_arm1 = 1'b0;
            gap_cnt1 = 0;
        end else begin
            if (stall1) begin
                chk("stall_valid1", 32'(tvalid1), 32'd1);
                chk("stall_data1", 32'(tdata1), 32'(sd1));
                chk("stall_last1", 32'(tlast1), 32'(sl1));
            end
            if (!tvalid1) chk("tlast_idle1", 32'(tlast1), 32'd0);
            if (tvalid1 && gap_arm1) begin
                chk("gap1", 32'(gap_cnt1), 32'(GAP));
                gap_arm1 = 1'b0;
            end else if (!tvalid1 && gap_arm1) begin
                gap_cnt1++;
            end
            if (tvalid1 && tready1) begin
                hs1++;
                if (q1.size() == 0) flag("unexpected_beat1", 32'(tdata1));
                else begin
                    b = q1.pop_front();
                    chk("data1", 32'(tdata1), b.d);
                    chk("keep1", 32'(tkeep1), 32'(b.k));
                    chk("last1", 32'(tlast1), 32'(b.l));
                end
                if (tlast1 && gap_chk1) begin
                    gap_arm1 = 1'b1;
                    gap_cnt1 = 0;
                end
            end
            stall1 = tvalid1 && !tready1;
            sd1    = tdata1;
            sl1    = tlast1;
        end
    end

    // Monitor / scoreboard for the 4-byte instance.
    always @(negedge clk) begin
        beat_t b;
        if (!reset && tvalid4 && tready4) begin
            if (q4.size() == 0) flag("unexpected_beat4", tdata4);
            else begin
                b = q4.pop_front();
                chk("data4", tdata4, b.d);
                chk("keep4", 32'(tkeep4), 32'(b.k));
                chk("last4", 32'(tlast4), 32'(b.l));
            end
        end
    end

    task automatic wait_empty(input int sel, input int budget);
        int cyc;
        cyc = 0;
        while (((sel == 1) ? q1.size() : q4.size()) != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (((sel == 1) ? q1.size() : q4.size()) != 0)
            flag("timeout_queue", 32'((sel == 1) ? q1.size() : q4.size()));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs1(input int n);
        int start;
        int cyc;
        start = hs1;
        cyc = 0;
        while (hs1 - start < n && cyc < 2000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (hs1 - start < n) flag("timeout_hs1", 32'(hs1 - start));
    endtask

    // Counts negedges with tvalid low from the moment enable is raised.
    task automatic measure_start1;
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!tvalid1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("start_latency1", 32'(cnt), 32'(GAP + 1));
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2;
        reset = 1'b1;
        q1.delete();
        seq1 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enable1 = 1'b0;
        enable4 = 1'b0;
        tready4 = 1'b1;
        #1;
        chk("rst_tvalid1", 32'(tvalid1), 32'd0);
        chk("rst_tlast1", 32'(tlast1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_tdata1", 32'(tdata1), 32'd0);
        chk("rst_tkeep1", 32'(tkeep1), 32'd0);
        chk("rst_fs1", 32'(fs1), 32'd0);
        chk("rst_tvalid4", 32'(tvalid4), 32'd0);
        chk("rst_tdata4", tdata4, 32'd0);
        chk("rst_tkeep4", 32'(tkeep4), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Continuous run to FRAME_COUNT with tready held high.
        gap_chk1 = 1'b1;
        push_frame1(0);
        push_frame1(1);
        push_frame1(0);
        @(posedge clk);
        #1;
        enable1 = 1'b1;
        measure_start1();
        wait_empty(1, 600);
        repeat (5) @(negedge clk);
        chk("a_done1", 32'(done1), 32'd1);
        chk("a_fs1", 32'(fs1), 32'd3);
        chk("a_busy1", 32'(busy1), 32'd0);
        chk("a_tvalid1", 32'(tvalid1), 32'd0);
        enable1 = 1'b0;

        // Same traffic under random backpressure.
        do_reset();
        chk("b_fs_after_rst1", 32'(fs1), 32'd0);
        chk("b_done_after_rst1", 32'(done1), 32'd0);
        rand1 = 1'b1;
        push_frame1(0);
        push_frame1(1);
        push_frame1(0);
        @(posedge clk);
        #1;
        enable1 = 1'b1;
        wait_empty(1, 2000);
        repeat (5) @(negedge clk);
        chk("b_done1", 32'(done1), 32'd1);
        chk("b_fs1", 32'(fs1), 32'd3);
        enable1 = 1'b0;
        rand1 = 1'b0;

        // Enable dropped mid-frame: frame completes, then IDLE; restart sends next message.
        gap_chk1 = 1'b0;
        do_reset();
        push_frame1(0);
        @(posedge clk);
        #1;
        enable1 = 1'b1;
        wait_hs1(3);
        enable1 = 1'b0;
        wait_empty(1, 200);
        repeat (3) @(negedge clk);
        chk("c_busy1", 32'(busy1), 32'd0);
        chk("c_tvalid1", 32'(tvalid1), 32'd0);
        chk("c_fs1", 32'(fs1), 32'd1);
        push_frame1(1);
        @(posedge clk);
        #1;
        enable1 = 1'b1;
        measure_start1();
        wait_hs1(2);
        enable1 = 1'b0;
        wait_empty(1, 200);
        repeat (3) @(negedge clk);
        chk("c_fs1_b", 32'(fs1), 32'd2);
        chk("c_busy1_b", 32'(busy1), 32'd0);

        // Reset pulsed mid-frame.
        do_reset();
        push_frame1(0);
        push_frame1(1);
        @(posedge clk);
        #1;
        enable1 = 1'b1;
        wait_hs1(16);
        chk("d_fs_before1", 32'(fs1), 32'd1);
        reset = 1'b1;
        q1.delete();
        seq1 = 8'd0;
        #1;
        chk("d_tvalid_rst1", 32'(tvalid1), 32'd0);
        chk("d_fs_rst1", 32'(fs1), 32'd0);
        chk("d_busy_rst1", 32'(busy1), 32'd0);
        push_frame1(0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_hs1(4);
        enable1 = 1'b0;
        wait_empty(1, 200);
        repeat (3) @(negedge clk);
        chk("d_fs_after1", 32'(fs1), 32'd1);

        // 4-byte lanes with partial tkeep on the last beat.
`ifdef MSG_FRAME_SEQ_NUM_EN
        push4(32'h48000200, 4'hF, 1'b0);
        push4(32'h00000049, 4'h1, 1'b1);
        push4(32'h41010500, 4'hF, 1'b0);
        push4(32'h45444342, 4'hF, 1'b1);
`else
        push4(32'h49480200, 4'hF, 1'b1);
        push4(32'h42410500, 4'hF, 1'b0);
        push4(32'h00454443, 4'h7, 1'b1);
`endif
        @(posedge clk);
        #1;
        enable4 = 1'b1;
        wait_empty(4, 200);
        repeat (5) @(negedge clk);
        chk("e_done4", 32'(done4), 32'd1);
        chk("e_fs4", 32'(fs4), 32'd2);
        chk("e_tvalid4", 32'(tvalid4), 32'd0);
        chk("e_busy4", 32'(busy4), 32'd0);
        enable4 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_frame_gen.md
# msg_frame_gen

Parametrised, length-prefixed message frame generator with an AXI-Stream-style master output. It cycles round-robin through `N_MSG` compile-time messages, each up to `MAX_LEN` bytes. Every frame carries a 2-byte big-endian length header, and the output bus is `BYTES` bytes wide with per-lane `tkeep`. It sits at the head of the TX path as a traffic source for MAC bring-up and loopback tests, feeding the framer/FIFO.

## Interface
- `BYTES`, 1: output width in bytes; legal values 1, 2, 4, 8.
- `N_MSG`, 2: number of stored messages; must be ≥1.
- `MAX_LEN`, 16: slot size in bytes per message.
- `MSG_LENS`, {16'd11, 16'd5}: packed 16-bit payload lengths. Message i uses `MSG_LENS[16*i+15 -: 16]`. Each value must be in 1..`MAX_LEN`; otherwise `$error` at elaboration.
- `MESSAGES`, "HELLO WORLD"/"ABCDE" padded: packed slots of 8*`MAX_LEN` bits. Slot i is `[8*MAX_LEN*(i+1)-1 -: 8*MAX_LEN]`. The payload is left-aligned, so payload byte 0 is the slot's most significant byte.
- `GAP_CYCLES`, 10: idle cycles before each frame.
- `FRAME_COUNT`, 20: number of frames to send before stopping; 0 means unlimited.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: start/continue generation.
- `tready` in 1: downstream ready.
- `tvalid` out 1: beat valid.
- `tdata` out 8*`BYTES`: beat data; frame byte k*`BYTES`+j is on lane j, `[8j+7:8j]`.
- `tkeep` out `BYTES`: lane j is set when that byte exists.
- `tlast` out 1: final beat of frame.
- `busy` out 1: high when not in IDLE or DONE.
- `frames_sent` out 16: count of completed frames; wraps at 65535→0.
- `done` out 1: `FRAME_COUNT` has been reached.

## Operation
- Frame byte sequence:
  - Byte 0 = len[15:8], byte 1 = len[7:0], then L payload bytes.
  - Frame size F = 2+L.
  - Beats = ceil(F/`BYTES`).
  - Unused lanes on the last beat drive 0 with `tkeep`=0.
- State machine IDLE, GAP, SEND, DONE:
  - IDLE: when `enable`=1, go to GAP with the counter cleared. If `GAP_CYCLES`=0, go straight to SEND.
  - GAP: the counter increments each cycle. At `GAP_CYCLES`-1, go to SEND. `enable` is ignored in this state.
  - SEND: `tvalid`=1. A handshake (`tvalid`&&`tready`) advances the beat index. A handshake on the last beat is one completed frame, and then:
    - `frames_sent`++ and msg_idx = (msg_idx+1) mod `N_MSG`.
    - If `FRAME_COUNT`≠0 and the new count equals `FRAME_COUNT`, go to DONE.
    - Else if `enable`, go to GAP (or SEND when `GAP_CYCLES`=0).
    - Else go to IDLE.
  - DONE: `done`=1, `tvalid`=0; held until `reset`.
- Deasserting `enable` mid-frame does not truncate the frame; the current frame completes.
- While `tvalid`=1 && `tready`=0, `tdata`/`tkeep`/`tlast` hold stable and `tvalid` must not drop.
- `tlast` is asserted only with `tvalid`, on the final beat.

## Timing
- Reset (asynchronous, immediate): state IDLE, msg_idx 0, beat 0, `frames_sent` 0. Outputs: `tvalid`/`tlast`/`busy`/`done` 0; `tdata`/`tkeep` 0.
- Reset mid-frame: the frame is abandoned. After release, the next frame is message 0, beat 0.
- All outputs are registered or decoded from registered state; there is no combinational path from `tready` to `tvalid`.
- Start latency: with the edge sampling `enable`=1 in IDLE as E0, `tvalid` first rises in the cycle after edge E0+`GAP_CYCLES`.
- Inter-frame gap: with the last-beat handshake at edge Et, `tvalid`=0 for exactly `GAP_CYCLES` cycles. When `GAP_CYCLES`=0, frames are back-to-back with no bubble.
- Throughput: 1 beat per cycle while `tready`=1.

## Configuration
- `MSG_FRAME_SEQ_NUM_EN` defined:
  - An 8-bit sequence byte is inserted after the length header, so F = 3+L.
  - Sequence value = `frames_sent`[7:0] at frame start; 0 for the first frame after reset, wraps 255→0.
  - The length field still equals L.
- Undefined: no sequence byte; F = 2+L.

## Test plan
- `BYTES`=1, one message "HELLO WORLD" (L=11), `GAP_CYCLES`=10, `FRAME_COUNT`=2, `tready`=1, `enable`=1 → beats 00,0B,48,45,4C,4C,4F,20,57,4F,52,4C,44 with `tlast` on the 13th; 10 idle cycles; the frame repeats; `done`=1 and `frames_sent`=2.
- Same configuration with random `tready` (50%) → identical byte sequence, and `tdata`/`tlast` never change while stalled.
- `BYTES`=4, "HI"(2) and "ABCDE"(5) →
  - Frame 1: `tdata`=0x49480200, `tkeep`=0xF, `tlast`.
  - Frame 2: 0x42410500/`tkeep` 0xF, then 0x00454443/`tkeep` 0x7 with `tlast`.
- `enable` dropped on beat 3 of 13 → the frame completes, then IDLE with `busy`=0. Reasserting `enable` → the next message after a 10-cycle gap.
- `reset` pulsed mid-frame → `tvalid` falls the same cycle and `frames_sent`=0. After release, the output restarts at 00,0B.
- `MSG_FRAME_SEQ_NUM_EN` defined, `BYTES`=1 → frame 0 is 00,0B,00,'H'…; frame 1 carries seq 01; the 257th frame carries seq 00.
